// File: rtl/crumb_pkg.sv
// Shared constants and types for the crumb serializer slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package crumb_pkg;

    localparam int WORD_W     = 8;
    localparam int CRUMB_W    = 2;
    localparam int NUM_CRUMBS = WORD_W / CRUMB_W;
    localparam int CNT_W      = $clog2(NUM_CRUMBS + 1);
    localparam int IDX_W      = $clog2(NUM_CRUMBS);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/crumb_len_detect.sv
// Crumb total for a word; trims leading zero crumbs under CRUMB_TRIM_EN, else constant 4.
// Latency: combinational.
// Backpressure: none.
module crumb_len_detect
    import crumb_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [CNT_W-1:0]  total
);

`ifdef CRUMB_TRIM_EN
    // A word of all zeros still needs one crumb so the receiver sees a beat.
    always_comb begin
        if (word[7:6] != 2'b00)      total = CNT_W'(4);
        else if (word[5:4] != 2'b00) total = CNT_W'(3);
        else if (word[3:2] != 2'b00) total = CNT_W'(2);
        else                         total = CNT_W'(1);
    end
`else
    logic unused_word;

    assign unused_word = ^word;
    assign total       = CNT_W'(NUM_CRUMBS);
`endif

endmodule

// File: rtl/crumb_serializer.sv
// Splits 8-bit words into 2-bit crumbs (order set by LSB_FIRST; CRUMB_TRIM_EN drops leading zero crumbs).
// Latency: first crumb valid one cycle after acceptance; back-to-back words with no bubble.
// Backpressure: valid/ready; outputs hold while out_ready is low, new word taken only in IDLE or on the last beat.
module crumb_serializer
    import crumb_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [CRUMB_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  total;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_start;
    logic              accept;
    logic              beat;

    crumb_len_detect u_len (
        .word  (in_data),
        .total (total)
    );

    // MSB-first starts at the highest crumb that survives trimming.
    assign idx_start = (LSB_FIRST != 0) ? '0 : IDX_W'(total - CNT_W'(1));
    assign out_data  = word_q[{idx_q, 1'b0} +: CRUMB_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        beat      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) state_d = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (count_q == CNT_W'(1));
                beat      = out_ready;
                in_ready  = out_last && out_ready;
                accept    = in_ready && in_valid;
                if (beat && out_last && !accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else if (accept) begin
            word_q  <= in_data;
            count_q <= total;
            idx_q   <= idx_start;
        end else if (beat) begin
            count_q <= count_q - CNT_W'(1);
            idx_q   <= (LSB_FIRST != 0) ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_crumb_serializer.sv
// Directed bench for crumb_serializer: one LSB-first and one MSB-first instance.
// Expectations follow CRUMB_TRIM_EN when the bench is built with it.
module tb_crumb_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       busy;

    logic [7:0] m_in_data = '0;
    logic       m_in_valid = 1'b0;
    logic       m_in_ready;
    logic [1:0] m_out_data;
    logic       m_out_valid;
    logic       m_out_ready = 1'b1;
    logic       m_out_last;
    logic       m_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    crumb_serializer #(.LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    crumb_serializer #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .rst_n(rst_n),
        .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_last(m_out_last), .busy(m_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one word with out_ready high and checks every crumb in order.
    task automatic send_word(input bit msb, input logic [7:0] w,
                             input logic [1:0] e0, input logic [1:0] e1,
                             input logic [1:0] e2, input logic [1:0] e3,
                             input int n, input string tag);
        logic [1:0] exp [4];
        exp = '{e0, e1, e2, e3};
        if (msb) begin m_in_data = w; m_in_valid = 1'b1; end
        else     begin in_data   = w; in_valid   = 1'b1; end
        #1 check({tag, "_rdy_idle"}, msb ? m_in_ready : in_ready, 1);
        tick();
        in_valid   = 1'b0;
        m_in_valid = 1'b0;
        #1;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_dat%0d", tag, k), msb ? m_out_data : out_data, exp[k]);
            check($sformatf("%s_vld%0d", tag, k), msb ? m_out_valid : out_valid, 1);
            check($sformatf("%s_last%0d", tag, k), msb ? m_out_last : out_last, (k == n - 1));
            check($sformatf("%s_rdy%0d", tag, k), msb ? m_in_ready : in_ready, (k == n - 1));
            tick();
        end
        check({tag, "_vld_end"}, msb ? m_out_valid : out_valid, 0);
        check({tag, "_busy_end"}, msb ? m_busy : busy, 0);
    endtask

    int n05, n00, n12, n3c, nm05;

    initial begin
`ifdef CRUMB_TRIM_EN
        n05 = 2; n00 = 1; n12 = 3; n3c = 3; nm05 = 2;
`else
        n05 = 4; n00 = 4; n12 = 4; n3c = 4; nm05 = 4;
`endif
        #2;
        check("rst_vld", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dat", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_rdy", in_ready, 1);
        #10 rst_n = 1'b1;
        tick();

        send_word(0, 8'hB4, 2'd0, 2'd1, 2'd3, 2'd2, 4, "b4_lsb");
        send_word(0, 8'h05, 2'd1, 2'd1, 2'd0, 2'd0, n05, "w05");
        send_word(0, 8'h00, 2'd0, 2'd0, 2'd0, 2'd0, n00, "w00");
        send_word(0, 8'hC0, 2'd0, 2'd0, 2'd0, 2'd3, 4, "wc0");

        // Backpressure on crumb 2 of 0xB4, with a competing word offered during the stall.
        in_data = 8'hB4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_dat0", out_data, 0);
        tick();
        check("bp_dat1", out_data, 1);
        tick();
        out_ready = 1'b0;
        in_data = 8'h55; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_hold_dat%0d", k), out_data, 3);
            check($sformatf("bp_hold_vld%0d", k), out_valid, 1);
            check($sformatf("bp_hold_last%0d", k), out_last, 0);
            check($sformatf("bp_hold_rdy%0d", k), in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 check("bp_dat2", out_data, 3);
        tick();
        check("bp_dat3", out_data, 2);
        check("bp_last3", out_last, 1);
        tick();
        check("bp_vld_end", out_valid, 0);

        // Back-to-back 0xFF then 0x12 with in_valid held high.
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_data = 8'h12;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b2b_ff_dat%0d", k), out_data, 3);
            check($sformatf("b2b_ff_vld%0d", k), out_valid, 1);
            check($sformatf("b2b_ff_rdy%0d", k), in_ready, (k == 3));
            tick();
        end
        in_valid = 1'b0;
        #1;
        begin
            logic [1:0] e12 [4];
            e12 = '{2'd2, 2'd0, 2'd1, 2'd0};
            for (int k = 0; k < n12; k++) begin
                check($sformatf("b2b_12_dat%0d", k), out_data, e12[k]);
                check($sformatf("b2b_12_vld%0d", k), out_valid, 1);
                check($sformatf("b2b_12_last%0d", k), out_last, (k == n12 - 1));
                tick();
            end
        end
        check("b2b_vld_end", out_valid, 0);

        // Reset in mid-word, then a clean word on the first edge after release.
        in_data = 8'hB4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_dat_pre", out_data, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", out_valid, 0);
        check("mid_rst_dat", out_data, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_busy", busy, 0);
        #2 rst_n = 1'b1;
        send_word(0, 8'h3C, 2'd0, 2'd3, 2'd3, 2'd0, n3c, "w3c");

        send_word(1, 8'hB4, 2'd2, 2'd3, 2'd1, 2'd0, 4, "b4_msb");
        if (nm05 == 2) send_word(1, 8'h05, 2'd1, 2'd1, 2'd0, 2'd0, 2, "w05_msb");
        else           send_word(1, 8'h05, 2'd0, 2'd0, 2'd1, 2'd1, 4, "w05_msb");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
